// File: rtl/sensor_sched.sv
// sensor_sched: periodic DS18B20/light scan scheduler with timeouts, result hold and display selection.
module sensor_sched #(
  parameter logic [31:0] PERIOD_CYC  = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd40_000_000,
  parameter logic [7:0]  ROT_SCANS   = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic        auto,
  output logic        ds_start,
  input  logic        ds_done,
  input  logic [15:0] ds_data,
  output logic        lt_start,
  input  logic        lt_done,
  input  logic [15:0] lt_data,
  output logic [15:0] dataout,
  output logic        flag,
  output logic        ds_valid,
  output logic        lt_valid,
  output logic [2:0]  err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, DS_REQ, DS_WAIT, LT_REQ, LT_WAIT} state_t;
  state_t state, state_nx;
  logic [31:0] per_cnt, wait_cnt;
  logic [7:0]  rot_cnt;
  logic [15:0] ds_reg, lt_reg;
  logic tick, ds_ok, ds_to, lt_ok, lt_to, scan_end, rot_hit;
  assign tick     = per_cnt == 32'd0;
  assign ds_ok    = state == DS_WAIT && ds_done;
  assign ds_to    = state == DS_WAIT && !ds_done && wait_cnt == TIMEOUT_CYC - 32'd1;
  assign lt_ok    = state == LT_WAIT && lt_done;
  assign lt_to    = state == LT_WAIT && !lt_done && wait_cnt == TIMEOUT_CYC - 32'd1;
  assign scan_end = lt_ok || lt_to;
  assign rot_hit  = auto && scan_end && rot_cnt == ROT_SCANS - 8'd1;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = tick ? DS_REQ : IDLE;
      DS_REQ:  state_nx = DS_WAIT;
      DS_WAIT: state_nx = (ds_ok || ds_to) ? LT_REQ : DS_WAIT;
      LT_REQ:  state_nx = LT_WAIT;
      LT_WAIT: state_nx = scan_end ? IDLE : LT_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    ds_start = state == DS_REQ;
    lt_start = state == LT_REQ;
    busy     = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_cnt  <= '0;
      wait_cnt <= '0;
      rot_cnt  <= '0;
      ds_reg   <= '0;
      lt_reg   <= '0;
      ds_valid <= 1'b0;
      lt_valid <= 1'b0;
      err      <= '0;
      flag     <= 1'b1;
      dataout  <= '0;
    end else begin
      per_cnt  <= per_cnt == PERIOD_CYC - 32'd1 ? 32'd0 : per_cnt + 32'd1;
      wait_cnt <= (state == DS_WAIT || state == LT_WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if (ds_ok) begin
        ds_reg   <= ds_data;
        ds_valid <= 1'b1;
        err[0]   <= 1'b0;
      end else if (ds_to) err[0] <= 1'b1;
      if (lt_ok) begin
        lt_reg   <= lt_data;
        lt_valid <= 1'b1;
        err[1]   <= 1'b0;
      end else if (lt_to) err[1] <= 1'b1;
      if (tick && state != IDLE) err[2] <= 1'b1;
      // a press and a rotate in the same cycle collapse into one toggle
      flag    <= flag ^ (btn || rot_hit);
      rot_cnt <= (btn || !auto || rot_hit) ? 8'd0 : scan_end ? rot_cnt + 8'd1 : rot_cnt;
      dataout <= flag ? ds_reg : lt_reg;
    end
  end
endmodule

// File: tb/tb_sensor_sched.sv
// tb_sensor_sched: directed scoreboard bench for sensor_sched (timeout 20 unit plus timeout 60 overrun unit).
module tb_sensor_sched;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0, auto = 1'b0, ds_done = 1'b0, lt_done = 1'b0;
  logic [15:0] ds_data = '0, lt_data = '0;
  logic ds_start, lt_start, flag, ds_valid, lt_valid, busy;
  logic [15:0] dataout;
  logic [2:0] err;
  logic b_ds_start, b_lt_start, b_flag, b_ds_valid, b_lt_valid, b_busy;
  logic [15:0] b_dataout;
  logic [2:0] b_err;
  int cyc = 0, a_starts = 0, b_starts = 0, n_chk = 0, n_fail = 0;
  int s1, l1, s2, l2, s, l;
  logic [15:0] exp_q[$];
  logic m_flag = 1'b1;
  int m_rot = 0;
  logic [15:0] m_ds = '0, m_lt = '0;

  sensor_sched #(.PERIOD_CYC(32'd100), .TIMEOUT_CYC(32'd20), .ROT_SCANS(8'd2)) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto(auto),
    .ds_start(ds_start), .ds_done(ds_done), .ds_data(ds_data),
    .lt_start(lt_start), .lt_done(lt_done), .lt_data(lt_data),
    .dataout(dataout), .flag(flag), .ds_valid(ds_valid), .lt_valid(lt_valid),
    .err(err), .busy(busy));

  sensor_sched #(.PERIOD_CYC(32'd100), .TIMEOUT_CYC(32'd60), .ROT_SCANS(8'd2)) dut_b (
    .clk(clk), .rst(rst), .btn(1'b0), .auto(1'b0),
    .ds_start(b_ds_start), .ds_done(1'b0), .ds_data(16'h0),
    .lt_start(b_lt_start), .lt_done(1'b0), .lt_data(16'h0),
    .dataout(b_dataout), .flag(b_flag), .ds_valid(b_ds_valid), .lt_valid(b_lt_valid),
    .err(b_err), .busy(b_busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      a_starts <= 0;
      b_starts <= 0;
    end else begin
      if (ds_start) a_starts <= a_starts + 1;
      if (b_ds_start) b_starts <= b_starts + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input bit is_lt, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (is_lt ? lt_start : ds_start) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed no strobe expected strobe within %0d cycles", is_lt ? "lt_start_wait" : "ds_start_wait", bound);
    end
  endtask

  task automatic do_scan(input bit ds_ok, input logic [15:0] dv, input bit lt_ok, input logic [15:0] lv,
                         input bit press, output int s_at, output int l_at);
    wait_start(1'b0, 130, s_at);
    if (ds_ok) begin
      repeat (5) @(negedge clk);
      ds_done = 1'b1;
      ds_data = dv;
      @(negedge clk);
      ds_done = 1'b0;
      m_ds = dv;
    end
    wait_start(1'b1, 30, l_at);
    if (lt_ok) begin
      repeat (3) @(negedge clk);
      lt_done = 1'b1;
      lt_data = lv;
      btn = press;
      @(negedge clk);
      lt_done = 1'b0;
      btn = 1'b0;
      m_lt = lv;
    end else repeat (22) @(negedge clk);
    if (press) begin
      m_flag = !m_flag;
      m_rot = 0;
    end else if (auto) begin
      m_rot++;
      if (m_rot == 2) begin
        m_flag = !m_flag;
        m_rot = 0;
      end
    end
  endtask

  task automatic post(input string tag);
    chk({tag, "_flag"}, 32'(flag), 32'(m_flag));
    exp_q.push_back(m_flag ? m_ds : m_lt);
    repeat (2) @(negedge clk);
    chk({tag, "_dataout"}, 32'(dataout), 32'(exp_q.pop_front()));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ds_start", 32'(ds_start), 0);
    chk("rst_lt_start", 32'(lt_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ds_valid", 32'(ds_valid), 0);
    chk("rst_lt_valid", 32'(lt_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dataout", 32'(dataout), 0);
    chk("rst_flag", 32'(flag), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("first_tick_start", 32'(ds_start), 1);
    chk("first_tick_busy", 32'(busy), 1);
    do_scan(1'b0, 16'h0, 1'b1, 16'h0321, 1'b0, s1, l1);
    chk("timeout_gap", 32'(l1 - s1), 21);
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_ds_valid", 32'(ds_valid), 0);
    chk("timeout_lt_valid", 32'(lt_valid), 1);
    post("scan1");
    do_scan(1'b1, 16'h0190, 1'b1, 16'h0321, 1'b0, s2, l2);
    chk("scan_period", 32'(s2 - s1), 100);
    chk("done_gap", 32'(l2 - s2), 6);
    chk("ok_err", 32'(err), 0);
    chk("ok_ds_valid", 32'(ds_valid), 1);
    chk("ok_lt_valid", 32'(lt_valid), 1);
    chk("b_overrun_err2", 32'(b_err[2]), 1);
    chk("b_no_extra_start", 32'(b_starts), 1);
    post("scan2");
    chk("a_start_count", 32'(a_starts), 2);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    m_flag = 1'b0;
    post("btn");
    auto = 1'b1;
    do_scan(1'b1, 16'h0190, 1'b1, 16'h0321, 1'b0, s, l);
    chk("b_start_count", 32'(b_starts), 2);
    chk("b_err_all", 32'(b_err), 32'h7);
    post("auto3");
    do_scan(1'b1, 16'h0190, 1'b1, 16'h0321, 1'b0, s, l);
    post("auto4");
    do_scan(1'b1, 16'h1234, 1'b1, 16'h0abc, 1'b0, s, l);
    post("auto5");
    do_scan(1'b1, 16'h1234, 1'b1, 16'h0abc, 1'b1, s, l);
    post("auto6_btn");
    do_scan(1'b1, 16'h1234, 1'b1, 16'h0abc, 1'b0, s, l);
    post("auto7");
    do_scan(1'b1, 16'h1234, 1'b1, 16'h0abc, 1'b0, s, l);
    post("auto8");
    chk("b_err2_sticky", 32'(b_err[2]), 1);
    auto = 1'b0;
    wait_start(1'b0, 130, s);
    repeat (3) @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ds_start", 32'(ds_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ds_valid", 32'(ds_valid), 0);
    chk("mid_rst_lt_valid", 32'(lt_valid), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_dataout", 32'(dataout), 0);
    chk("mid_rst_flag", 32'(flag), 1);
    chk("mid_rst_b_err", 32'(b_err), 0);
    rst = 1'b1;
    ds_done = 1'b1;
    ds_data = 16'hbeef;
    @(negedge clk);
    ds_done = 1'b0;
    chk("rel_ds_start", 32'(ds_start), 1);
    chk("rel_ds_valid", 32'(ds_valid), 0);
    repeat (10) @(negedge clk);
    chk("late_done_valid", 32'(ds_valid), 0);
    chk("late_done_dataout", 32'(dataout), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_sched.md
# sensor_sched

Scan scheduler for the two board sensors, the DS18B20 temperature driver and the light-sensor reader. It periodically sequences one conversion on each sensor, so the two drivers never run at once. It guards each conversion with a timeout and holds the last good result from each. It also owns display selection (button toggle or auto-rotate) and drives the 16-bit value sent to the display encoder.

## Interface
- PERIOD_CYC, 50_000_000: scan period in clk cycles (≥ 4, 32-bit).
- TIMEOUT_CYC, 40_000_000: maximum wait for a sensor `done`, in cycles (≥ 2, 32-bit).
- ROT_SCANS, 4: completed scans between display toggles in auto mode (≥ 1, 8-bit).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- btn  in  1  single-cycle debounced press pulse; toggles display selection.
- auto  in  1  level; 1 enables auto-rotate of the display selection.
- ds_start  out  1  one-cycle start strobe to the DS18B20 driver.
- ds_done  in  1  one-cycle completion pulse from the DS18B20 driver.
- ds_data  in  16  temperature word, valid in the cycle `ds_done` is high.
- lt_start  out  1  one-cycle start strobe to the light reader.
- lt_done  in  1  one-cycle completion pulse from the light reader.
- lt_data  in  16  light word, valid in the cycle `lt_done` is high.
- dataout  out  16  selected sensor value for display.
- flag  out  1  display selection: 1 = temperature, 0 = light.
- ds_valid, lt_valid  out  1 each  set on the first good result; cleared only by reset.
- err  out  3  [0] last DS scan timed out, [1] last light scan timed out, [2] sticky period overrun.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- The period counter free-runs 0..PERIOD_CYC-1 and wraps to 0. A tick occurs in every cycle where the count is 0.
- FSM states are IDLE, DS_REQ, DS_WAIT, LT_REQ, LT_WAIT.
  - IDLE: on a tick, go to DS_REQ.
  - DS_REQ: assert `ds_start` for this cycle only, clear the wait counter, go to DS_WAIT.
  - DS_WAIT: wait counter increments each cycle.
    - If `ds_done` is high: latch `ds_data` into the DS register, set `ds_valid`, clear err[0], go to LT_REQ.
    - Otherwise, when the wait count reaches TIMEOUT_CYC-1: set err[0], keep the old DS register, go to LT_REQ.
  - LT_REQ and LT_WAIT: same behaviour using the `lt_*` signals and err[1]. Both exits return to IDLE and count one completed scan.
- If `done` and timeout occur in the same cycle, the result counts as a success.
- `ds_done` and `lt_done` arriving outside their own WAIT state are ignored.
- A tick that occurs while not in IDLE is dropped and sets err[2]; err[2] clears only on reset.
- Display selection:
  - A `btn` pulse toggles `flag` and clears the rotate scan counter.
  - With `auto`=1, each completed scan increments the rotate counter. When it reaches ROT_SCANS, `flag` toggles and the counter returns to 0.
  - With `auto`=0, the rotate counter holds at 0.
  - If a `btn` pulse and a rotate toggle fall in the same cycle, `flag` toggles once and the counter clears.
- `dataout` is registered each cycle from the DS register when `flag`=1, else from the light register.

## Timing
- Reset (`rst`=0 at a clock edge):
  - Counters, state and both data registers go to 0; FSM goes to IDLE.
  - `ds_start`, `lt_start`, `busy`, `ds_valid`, `lt_valid`, `err` and `dataout` go to 0.
  - `flag` goes to 1.
  - Reset mid-scan kills any strobe immediately; a late `done` after reset is ignored.
- The first cycle after reset release is a tick, so a scan starts at once.
- Tick at cycle T: `ds_start` is high at T+1 and `busy` is high from T+1.
- `ds_done` at cycle W: DS register updates at W+1, `lt_start` is high at W+1, and `dataout` reflects the new value at W+2 if `flag`=1.
- Timeout exit: `ds_start` at S, then `lt_start` at S+TIMEOUT_CYC+1.
- Flag change at cycle F (registered): `dataout` switches at F+1.

## Test plan
- PERIOD_CYC=100, TIMEOUT_CYC=20, ROT_SCANS=2. Release reset, then return `ds_done` with 16'h0190 5 cycles after `ds_start` and `lt_done` with 16'h0321 3 cycles after `lt_start` -> one `ds_start` pulse then one `lt_start` pulse per scan; `dataout`=16'h0190; `ds_valid`=`lt_valid`=1; `err`=0; scans start 100 cycles apart.
- Same params, never assert `ds_done` -> `lt_start` fires 21 cycles after `ds_start`; err[0]=1; `ds_valid`=0; `dataout`=0 with `flag`=1. Next scan returns `ds_done` -> err[0] clears.
- Pulse `btn` once after the first scan -> `flag`=0 and `dataout`=16'h0321 one cycle later. Assert `btn` in the same cycle as an `auto` rotate toggle -> `flag` toggles exactly once.
- `auto`=1 with no `btn` -> `flag` toggles after every 2nd completed scan.
- Set TIMEOUT_CYC=60 with no `done` on either sensor -> a tick lands in LT_WAIT, err[2] sets and stays set; no extra `ds_start` is issued.
- Pull `rst` low during DS_WAIT, then pulse `ds_done` right after release -> all outputs at their reset values, the `done` pulse is ignored, and a fresh `ds_start` appears one cycle after release.
